// File: rtl/dp_fpu_pkg.sv
// Shared FPU types: exception-flag vector, flag bit positions, the canonical quiet NaN
// and the default adder retire entry.
package dp_fpu_pkg;
  typedef logic [4:0] fflags_t;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;
  localparam int          DP_TAG_W = 5;

  typedef struct packed {
    logic [63:0]         result;
    logic [DP_TAG_W-1:0] tag;
    fflags_t             flags;
  } dp_add_entry_t;

  // The adder never divides, so DZ is always clear.
  function automatic fflags_t pack_flags(input logic nv, input logic of_, input logic uf,
                                         input logic nx);
    fflags_t f;
    f        = '0;
    f[FF_NV] = nv;
    f[FF_DZ] = 1'b0;
    f[FF_OF] = of_;
    f[FF_UF] = uf;
    f[FF_NX] = nx;
    return f;
  endfunction
endpackage

// File: rtl/dp_add_result_stage_if.sv
// Adder-to-retire-stage and retire-stage-to-writeback handshakes bundled in one interface.
interface dp_add_result_if #(parameter int TAG_W = 5);
  import dp_fpu_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_result;
  logic             in_nv, in_of, in_uf, in_nx;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  fflags_t          out_fflags;

  modport slave (
    input  in_valid, in_result, in_nv, in_of, in_uf, in_nx, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_fflags
  );
  modport master (
    output in_valid, in_result, in_nv, in_of, in_uf, in_nx, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_fflags
  );
endinterface

// File: rtl/dp_result_fifo.sv
// DEPTH-entry in-order FIFO with wrap-bit pointers; flush drops everything by snapping rd to wr.
module dp_result_fifo
  import dp_fpu_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = dp_add_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  input  logic          flush,
  output T              rdata,
  output logic          empty,
  output logic          full,
  output logic [PW-1:0] count
);
  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (flush)                rd_ptr <= wr_ptr;
      else if (pop && !empty)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/dp_add_result_stage.sv
// Retire stage after the DP adder: queues result/tag/flags for writeback and accrues sticky
// fflags. Define DP_ADD_FLAG_ACCRUE_EN to build the sticky register and its CSR write port.
module dp_add_result_stage
  import dp_fpu_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter int  TAG_W = 5,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dp_add_result_if.slave    io,
  input  logic              flush,
  input  logic              fflags_wr,
  input  fflags_t           fflags_wdata,
  output fflags_t           fflags_o,
  output logic [CW-1:0]     count
);
  typedef struct packed {
    logic [63:0]      result;
    logic [TAG_W-1:0] tag;
    fflags_t          flags;
  } entry_t;

  entry_t wr_entry, head;
  logic   empty, full, push, pop, rdy_en;

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Registered state only: out_ready never reaches in_ready.
  assign io.in_ready  = rdy_en & ~full & ~flush;
  assign push         = io.in_valid & io.in_ready;
  assign io.out_valid = ~empty;
  assign pop          = io.out_valid & io.out_ready;

  assign wr_entry.result = io.in_result;
  assign wr_entry.tag    = io.in_tag;
  assign wr_entry.flags  = pack_flags(io.in_nv, io.in_of, io.in_uf, io.in_nx);

  dp_result_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign io.out_result = empty ? '0 : head.result;
  assign io.out_tag    = empty ? '0 : head.tag;
  assign io.out_fflags = empty ? '0 : head.flags;

`ifdef DP_ADD_FLAG_ACCRUE_EN
  fflags_t fflags_q;
  // A popped entry's flags are ORed over a same-cycle CSR write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fflags_q <= '0;
    else        fflags_q <= (fflags_wr ? fflags_wdata : fflags_q) | (pop ? head.flags : '0);
  end
  assign fflags_o = fflags_q;
`else
  logic unused_csr;
  assign unused_csr = ^{fflags_wr, fflags_wdata};
  assign fflags_o   = '0;
`endif
endmodule
